// File: rtl/div_unit.sv
// Multi-cycle restoring radix-2 integer divider for div.w/div.wu/mod.w/mod.wu.
// One quotient bit per cycle, valid/ready on request and result, flush abandons work.
module div_unit #(
  parameter int unsigned ITERS = 32
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        div_valid,
  output logic        div_ready,
  input  logic        div_signed,
  input  logic        div_is_mod,
  input  logic [31:0] div_src1,
  input  logic [31:0] div_src2,
  input  logic        div_flush,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] div_result,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [5:0]  cnt;
  logic [63:0] rq;
  logic [31:0] dvs;
  logic        q_neg;
  logic        r_neg;
  logic        is_mod;
  logic        dz;
  logic [31:0] result_q;

  logic        hs;
  logic        last;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [32:0] trial_hi;
  logic        trial_ge;
  logic [31:0] rem_sub;
  logic [31:0] q_fix;
  logic [31:0] r_fix;

  assign hs   = div_valid && (state == S_IDLE) && !div_flush;
  assign last = (cnt == 6'(ITERS - 1));

  assign a_mag = (div_signed && div_src1[31]) ? -div_src1 : div_src1;
  assign b_mag = (div_signed && div_src2[31]) ? -div_src2 : div_src2;

  // Upper 33 bits after the shift; the difference always fits in 32 bits when taken.
  assign trial_hi = rq[63:31];
  assign trial_ge = (trial_hi >= {1'b0, dvs});
  assign rem_sub  = trial_hi[31:0] - dvs;

  // Zero divisor yields all-ones quotient bits and |src1| as remainder, so only
  // the quotient needs overriding; the remainder sign fix restores src1.
  assign q_fix = dz ? '1 : (q_neg ? -rq[31:0] : rq[31:0]);
  assign r_fix = r_neg ? -rq[63:32] : rq[63:32];

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (hs) state_nx = S_CALC;
      S_CALC: if (last) state_nx = S_FIX;
      S_FIX:  state_nx = S_DONE;
      S_DONE: if (res_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    if (div_flush) state_nx = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt      <= '0;
      rq       <= '0;
      dvs      <= '0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      is_mod   <= 1'b0;
      dz       <= 1'b0;
      result_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (hs) begin
            rq     <= {32'd0, a_mag};
            dvs    <= b_mag;
            q_neg  <= div_signed && (div_src1[31] ^ div_src2[31]);
            r_neg  <= div_signed && div_src1[31];
            is_mod <= div_is_mod;
            dz     <= (div_src2 == '0);
            cnt    <= '0;
          end
        end
        S_CALC: begin
          if (trial_ge) rq <= {rem_sub, rq[30:0], 1'b1};
          else          rq <= {rq[62:0], 1'b0};
          cnt <= cnt + 6'd1;
        end
        S_FIX: begin
          if (!div_flush) result_q <= is_mod ? r_fix : q_fix;
        end
        default: ;
      endcase
    end
  end

  assign div_ready  = (state == S_IDLE);
  assign busy       = (state == S_CALC) || (state == S_FIX);
  assign res_valid  = (state == S_DONE);
  assign div_result = result_q;

endmodule
